exe_stage: RTL and testbench
============================

# exe_stage

Execute stage of the five-stage in-order pipeline, between the decode stage and the memory stage. It latches the decode bundle, computes single-cycle ALU results through the team's `alu` module, and runs a 32-iteration radix-2 divider for divide/modulo instructions. It issues the data-SRAM request for loads and stores, and forwards a 71-bit bundle to the memory stage. Stalls are governed by the pipeline's standard valid/allowin handshake.

## Interface
- No parameters. Bus widths come from `mycpu.h`: `DS_TO_ES_BUS_WD` = 151, `ES_TO_MS_BUS_WD` = 71.
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high.
- ms_allowin  in  1  memory stage can accept.
- es_allowin  out  1  this stage can accept.
- ds_to_es_valid  in  1  decode bundle valid.
- ds_to_es_bus  in  151  decode bundle, MSB first:
  - alu_op[11:0]
  - div_op[2:0]: bit2 = div, bit1 = signed, bit0 = select remainder
  - res_from_mem
  - gr_we
  - mem_we
  - dest[4:0]
  - src1[31:0]
  - src2[31:0]
  - rkd_value[31:0]
  - pc[31:0]
- es_to_ms_valid  out  1  bundle valid to memory stage.
- es_to_ms_bus  out  71  {res_from_mem, gr_we, dest[4:0], result[31:0], pc[31:0]}.
- es_dest  out  5  dest of a valid gr_we instruction, else 0 (hazard).
- es_load  out  1  es_valid & res_from_mem (load-use hazard).
- data_sram_en  out  1  SRAM request enable.
- data_sram_we  out  4  byte write enables.
- data_sram_addr  out  32  = ALU result.
- data_sram_wdata  out  32  = rkd_value.

## Operation
- Bundle register and es_valid use the standard handshake:
  - es_allowin = !es_valid | (es_ready_go & ms_allowin).
  - The bundle is latched only when ds_to_es_valid & es_allowin.
- Non-divide instructions: es_ready_go = 1; result = alu(alu_op, src1, src2).
- Divide FSM with states IDLE, BUSY, DONE; a 5-bit iteration counter; 64-bit partial remainder; 32-bit quotient.
  - IDLE: when es_valid & div_op[2], load |src1| and |src2| (absolute values only if div_op[1]), clear the counter, go to BUSY.
  - BUSY: each cycle performs one restoring step (shift, trial subtract, set quotient bit). After the counter reaches 31, go to DONE.
  - DONE: es_ready_go = 1. Hold the result until ms_allowin, then go to IDLE on the transfer edge.
- Signed fix-up (DONE):
  - The quotient is negated when the operand signs differ.
  - The remainder takes the sign of the dividend.
  - -2^31 / -1 gives quotient 0x80000000, remainder 0.
- Divide by zero: quotient = 0xFFFFFFFF and remainder = src1, for both signed and unsigned.
- Result select: div_op[0] ? remainder : quotient when div_op[2], else the ALU result.
- SRAM request:
  - data_sram_en = es_valid & es_ready_go & (res_from_mem | mem_we).
  - data_sram_we = 4'hF only if es_valid & es_ready_go & mem_we, else 0.
  - A stalled store is re-presented with identical address and data, which is harmless.

## Timing
- Reset (async): es_valid = 0, FSM = IDLE, counter = 0. Consequently es_to_ms_valid = 0, es_allowin = 1, es_dest = 0, es_load = 0, data_sram_en = 0, data_sram_we = 0. The bundle register is not reset.
- Non-divide latency: 1 cycle in EX; es_to_ms_valid = es_valid.
- Divide latency, with the bundle latched at edge T:
  - Cycle T: IDLE, es_ready_go = 0.
  - Cycles T+1..T+32: BUSY.
  - Cycle T+33: DONE, es_to_ms_valid = 1.
  - Minimum occupancy is 34 cycles. Extra ms_allowin = 0 cycles extend DONE without changing the result.
- A divide followed back-to-back by a divide re-enters IDLE on the transfer edge and starts fresh on the next cycle; no state leaks between them.
- es_allowin = 0 throughout IDLE(div) and BUSY.
- Reset asserted mid-divide aborts at once; no bundle is emitted.

## Configuration
- `EXE_DIV_EN` defined: divider and FSM as above.
- `EXE_DIV_EN` undefined:
  - Divider logic is absent; div_op is ignored.
  - The ALU result is always used, and es_ready_go = 1 for every instruction.

## Test plan
- add.w, src1 = 5, src2 = 7, ms_allowin = 1 -> one cycle later es_to_ms_bus result = 12, gr_we and dest are passed through, es_dest = dest.
- Store with src1 + src2 = 0x1000 and rkd_value = 0xDEADBEEF -> data_sram_en = 1, we = 4'hF, addr = 0x1000, wdata = 0xDEADBEEF for exactly the cycle that es_ready_go = 1.
- Unsigned div 100 / 7 -> es_to_ms_valid rises 33 cycles after latch with result 14. Repeating with the remainder select gives 2. es_allowin stays low in between.
- Signed div and mod:
  - -7 / 2 -> 0xFFFFFFFD; -7 % 2 -> 0xFFFFFFFF.
  - 0x80000000 / -1 -> 0x80000000.
  - x / 0 with x = 9 -> quotient 0xFFFFFFFF, remainder 9.
- ms_allowin held at 0 for 5 cycles after DONE -> result stable, then one transfer. Reset pulsed at BUSY iteration 10 -> es_to_ms_valid = 0 and es_allowin = 1 immediately.
- Build without `EXE_DIV_EN`: a divide instruction completes in 1 cycle with the ALU result.

Source files
------------

// File: rtl/exe_stage.sv
// Execute stage: latches the decode bundle, computes ALU results, issues the data-SRAM request.
// Define EXE_DIV_EN to build the 32-iteration radix-2 restoring divider for div/mod instructions.

module alu (
    input  logic [11:0] alu_op,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);
    // alu_op one-hot: add sub slt sltu and nor or xor sll srl sra lui (bit 0 .. bit 11)
    logic        w_invert;
    logic [32:0] w_sum;
    logic [31:0] w_b;
    logic        w_slt;
    logic        w_sltu;
    logic [31:0] w_sra;

    assign w_invert = alu_op[1] | alu_op[2] | alu_op[3];
    assign w_b      = w_invert ? ~alu_src2 : alu_src2;
    assign w_sum    = {1'b0, alu_src1} + {1'b0, w_b} + {32'b0, w_invert};
    assign w_slt    = (alu_src1[31] & ~alu_src2[31])
                    | (~(alu_src1[31] ^ alu_src2[31]) & w_sum[31]);
    assign w_sltu   = ~w_sum[32];
    assign w_sra    = $signed(alu_src1) >>> alu_src2[4:0];

    assign alu_result = ({32{alu_op[0] | alu_op[1]}} & w_sum[31:0])
                      | ({32{alu_op[2]}}  & {31'b0, w_slt})
                      | ({32{alu_op[3]}}  & {31'b0, w_sltu})
                      | ({32{alu_op[4]}}  & (alu_src1 & alu_src2))
                      | ({32{alu_op[5]}}  & ~(alu_src1 | alu_src2))
                      | ({32{alu_op[6]}}  & (alu_src1 | alu_src2))
                      | ({32{alu_op[7]}}  & (alu_src1 ^ alu_src2))
                      | ({32{alu_op[8]}}  & (alu_src1 << alu_src2[4:0]))
                      | ({32{alu_op[9]}}  & (alu_src1 >> alu_src2[4:0]))
                      | ({32{alu_op[10]}} & w_sra)
                      | ({32{alu_op[11]}} & alu_src2);
endmodule

module exe_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         ms_allowin,
    output logic         es_allowin,
    input  logic         ds_to_es_valid,
    input  logic [150:0] ds_to_es_bus,
    output logic         es_to_ms_valid,
    output logic [70:0]  es_to_ms_bus,
    output logic [4:0]   es_dest,
    output logic         es_load,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_we,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata
);
    logic         r_es_valid;
    logic [150:0] r_bus;

    logic [11:0]  w_alu_op;
    logic [2:0]   w_div_op;
    logic         w_res_from_mem;
    logic         w_gr_we;
    logic         w_mem_we;
    logic [4:0]   w_dest;
    logic [31:0]  w_src1;
    logic [31:0]  w_src2;
    logic [31:0]  w_rkd_value;
    logic [31:0]  w_pc;
    logic [31:0]  w_alu_result;
    logic [31:0]  w_result;
    logic         w_es_ready_go;

    assign {w_alu_op, w_div_op, w_res_from_mem, w_gr_we, w_mem_we, w_dest,
            w_src1, w_src2, w_rkd_value, w_pc} = r_bus;

    assign es_allowin = ~r_es_valid | (w_es_ready_go & ms_allowin);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_es_valid <= 1'b0;
        end else if (es_allowin) begin
            r_es_valid <= ds_to_es_valid;
        end
    end

    // The bundle itself carries no reset; es_valid qualifies every use of it.
    always_ff @(posedge clk) begin
        if (ds_to_es_valid & es_allowin) begin
            r_bus <= ds_to_es_bus;
        end
    end

    alu u_alu (
        .alu_op     (w_alu_op),
        .alu_src1   (w_src1),
        .alu_src2   (w_src2),
        .alu_result (w_alu_result)
    );

`ifdef EXE_DIV_EN
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    div_state_t   r_state;
    div_state_t   w_next_state;
    logic [4:0]   r_cnt;
    logic [63:0]  r_rem;
    logic [31:0]  r_quot;
    logic [31:0]  r_divisor;
    logic         w_is_div;
    logic         w_start;
    logic [31:0]  w_abs1;
    logic [31:0]  w_abs2;
    logic [33:0]  w_trial;
    logic         w_unused_trial_bit;
    logic         w_div_zero;
    logic         w_neg_q;
    logic         w_neg_r;
    logic [31:0]  w_quot;
    logic [31:0]  w_rem;

    assign w_is_div = w_div_op[2];
    assign w_start  = (r_state == DIV_IDLE) & r_es_valid & w_is_div;
    assign w_abs1   = (w_div_op[1] & w_src1[31]) ? -w_src1 : w_src1;
    assign w_abs2   = (w_div_op[1] & w_src2[31]) ? -w_src2 : w_src2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= DIV_IDLE;
            r_cnt   <= 5'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == DIV_BUSY) begin
                r_cnt <= r_cnt + 5'd1;
            end else begin
                r_cnt <= 5'd0;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            DIV_IDLE: if (w_start)          w_next_state = DIV_BUSY;
            DIV_BUSY: if (r_cnt == 5'd31)   w_next_state = DIV_DONE;
            DIV_DONE: if (ms_allowin)       w_next_state = DIV_IDLE;
            default:                        w_next_state = DIV_IDLE;
        endcase
    end

    // Shifted partial remainder is 33 bits wide; the extra guard bit keeps the trial sign honest.
    assign w_trial            = {1'b0, r_rem[63:31]} - {2'b00, r_divisor};
    assign w_unused_trial_bit = w_trial[32];

    always_ff @(posedge clk) begin
        if (w_start) begin
            r_rem     <= {32'b0, w_abs1};
            r_quot    <= 32'b0;
            r_divisor <= w_abs2;
        end else if (r_state == DIV_BUSY) begin
            if (!w_trial[33]) begin
                r_rem  <= {w_trial[31:0], r_rem[30:0], 1'b0};
                r_quot <= {r_quot[30:0], 1'b1};
            end else begin
                r_rem  <= {r_rem[62:0], 1'b0};
                r_quot <= {r_quot[30:0], 1'b0};
            end
        end
    end

    assign w_div_zero = (w_src2 == 32'b0);
    assign w_neg_q    = w_div_op[1] & (w_src1[31] ^ w_src2[31]);
    assign w_neg_r    = w_div_op[1] & w_src1[31];
    assign w_quot     = w_div_zero ? 32'hFFFF_FFFF : (w_neg_q ? -r_quot : r_quot);
    assign w_rem      = w_div_zero ? w_src1 : (w_neg_r ? -r_rem[63:32] : r_rem[63:32]);

    assign w_es_ready_go = ~w_is_div | (r_state == DIV_DONE);
    assign w_result      = w_is_div ? (w_div_op[0] ? w_rem : w_quot) : w_alu_result;
`else
    logic [2:0] w_unused_div_op;

    assign w_unused_div_op = w_div_op;
    assign w_es_ready_go   = 1'b1;
    assign w_result        = w_alu_result;
`endif

    assign es_to_ms_valid  = r_es_valid & w_es_ready_go;
    assign es_to_ms_bus    = {w_res_from_mem, w_gr_we, w_dest, w_result, w_pc};
    assign es_dest         = (r_es_valid & w_gr_we) ? w_dest : 5'd0;
    assign es_load         = r_es_valid & w_res_from_mem;

    // A stalled store re-presents the same address and data, so repeats are harmless.
    assign data_sram_en    = r_es_valid & w_es_ready_go & (w_res_from_mem | w_mem_we);
    assign data_sram_we    = {4{r_es_valid & w_es_ready_go & w_mem_we}};
    assign data_sram_addr  = w_alu_result;
    assign data_sram_wdata = w_rkd_value;
endmodule

// File: tb/tb_exe_stage.sv
// Directed testbench for exe_stage; divider checks are built only when EXE_DIV_EN is defined.

module tb_exe_stage;
    logic         clk;
    logic         reset;
    logic         ms_allowin;
    logic         es_allowin;
    logic         ds_to_es_valid;
    logic [150:0] ds_to_es_bus;
    logic         es_to_ms_valid;
    logic [70:0]  es_to_ms_bus;
    logic [4:0]   es_dest;
    logic         es_load;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    int n_cmp = 0;
    int n_mis = 0;

    localparam logic [11:0] OP_ADD = 12'h001;
    localparam logic [11:0] OP_SUB = 12'h002;
    localparam logic [11:0] OP_SLT = 12'h004;
    localparam logic [11:0] OP_XOR = 12'h080;
    localparam logic [11:0] OP_SRA = 12'h400;
    localparam logic [31:0] PC0    = 32'h1C00_0000;

    exe_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ms_allowin      (ms_allowin),
        .es_allowin      (es_allowin),
        .ds_to_es_valid  (ds_to_es_valid),
        .ds_to_es_bus    (ds_to_es_bus),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .es_dest         (es_dest),
        .es_load         (es_load),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [150:0] mk(input logic [11:0] op, input logic [2:0] dop,
                                        input logic rfm, input logic gwe, input logic mwe,
                                        input logic [4:0] dest, input logic [31:0] s1,
                                        input logic [31:0] s2, input logic [31:0] rkd,
                                        input logic [31:0] pc);
        return {op, dop, rfm, gwe, mwe, dest, s1, s2, rkd, pc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [70:0] obs, input logic [70:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

`ifdef EXE_DIV_EN
    task automatic run_div(input string tag, input logic [31:0] s1, input logic [31:0] s2,
                           input logic [2:0] dop, input logic [31:0] exp, input int hold);
        int   cyc;
        logic saw_allow;
        cyc            = 0;
        saw_allow      = 1'b0;
        ms_allowin     = (hold == 0);
        ds_to_es_bus   = mk(OP_ADD, dop, 1'b0, 1'b1, 1'b0, 5'd4, s1, s2, 32'd0, PC0);
        ds_to_es_valid = 1'b1;
        step();
        ds_to_es_valid = 1'b0;
        while (!es_to_ms_valid && cyc < 100) begin
            saw_allow = saw_allow | es_allowin;
            step();
            cyc++;
        end
        check({tag, " latency"}, 71'(cyc), 71'd33);
        check({tag, " allowin_low"}, 71'(saw_allow), 71'd0);
        check({tag, " result"}, 71'(es_to_ms_bus[63:32]), 71'(exp));
        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, " hold_valid"}, 71'(es_to_ms_valid), 71'd1);
            check({tag, " hold_result"}, 71'(es_to_ms_bus[63:32]), 71'(exp));
        end
        ms_allowin = 1'b1;
        step();
        check({tag, " drained"}, 71'(es_to_ms_valid), 71'd0);
    endtask
`endif

    initial begin
        reset          = 1'b1;
        ms_allowin     = 1'b1;
        ds_to_es_valid = 1'b0;
        ds_to_es_bus   = '0;
        #3;
        check("rst es_to_ms_valid", 71'(es_to_ms_valid), 71'd0);
        check("rst es_allowin", 71'(es_allowin), 71'd1);
        check("rst es_dest", 71'(es_dest), 71'd0);
        check("rst es_load", 71'(es_load), 71'd0);
        check("rst sram_en", 71'(data_sram_en), 71'd0);
        check("rst sram_we", 71'(data_sram_we), 71'd0);
        step();
        step();
        reset = 1'b0;
        step();

        // add.w 5 + 7 into r3
        ds_to_es_bus   = mk(OP_ADD, 3'b000, 1'b0, 1'b1, 1'b0, 5'd3, 32'd5, 32'd7, 32'd0, PC0);
        ds_to_es_valid = 1'b1;
        step();
        ds_to_es_valid = 1'b0;
        check("add valid", 71'(es_to_ms_valid), 71'd1);
        check("add bus", es_to_ms_bus, {1'b0, 1'b1, 5'd3, 32'd12, PC0});
        check("add es_dest", 71'(es_dest), 71'd3);
        check("add sram_en", 71'(data_sram_en), 71'd0);
        step();
        check("add drained", 71'(es_to_ms_valid), 71'd0);
        check("idle es_dest", 71'(es_dest), 71'd0);

        // store 0xDEADBEEF to 0xF00 + 0x100, then a load right behind it
        ds_to_es_bus   = mk(OP_ADD, 3'b000, 1'b0, 1'b0, 1'b1, 5'd9, 32'h0F00, 32'h0100,
                            32'hDEAD_BEEF, PC0 + 32'd4);
        ds_to_es_valid = 1'b1;
        step();
        check("st sram_en", 71'(data_sram_en), 71'd1);
        check("st sram_we", 71'(data_sram_we), 71'hF);
        check("st sram_addr", 71'(data_sram_addr), 71'h1000);
        check("st sram_wdata", 71'(data_sram_wdata), 71'hDEAD_BEEF);
        check("st es_dest", 71'(es_dest), 71'd0);
        ds_to_es_bus   = mk(OP_ADD, 3'b000, 1'b1, 1'b1, 1'b0, 5'd7, 32'h2000, 32'h4,
                            32'd0, PC0 + 32'd8);
        step();
        ds_to_es_valid = 1'b0;
        check("ld es_load", 71'(es_load), 71'd1);
        check("ld sram_en", 71'(data_sram_en), 71'd1);
        check("ld sram_we", 71'(data_sram_we), 71'd0);
        check("ld sram_addr", 71'(data_sram_addr), 71'h2004);
        check("ld es_dest", 71'(es_dest), 71'd7);
        step();
        check("ld drained sram_en", 71'(data_sram_en), 71'd0);

        // sub held by ms_allowin = 0 while an xor waits upstream
        ms_allowin     = 1'b0;
        ds_to_es_bus   = mk(OP_SUB, 3'b000, 1'b0, 1'b1, 1'b0, 5'd10, 32'd20, 32'd8, 32'd0, PC0);
        ds_to_es_valid = 1'b1;
        step();
        ds_to_es_bus   = mk(OP_XOR, 3'b000, 1'b0, 1'b1, 1'b0, 5'd11, 32'hFF00_FF00,
                            32'h0F0F_0F0F, 32'd0, PC0);
        check("stall allowin", 71'(es_allowin), 71'd0);
        check("stall sub result", 71'(es_to_ms_bus[63:32]), 71'd12);
        step();
        step();
        check("stall still valid", 71'(es_to_ms_valid), 71'd1);
        check("stall result held", 71'(es_to_ms_bus[63:32]), 71'd12);
        ms_allowin = 1'b1;
        step();
        check("xor result", 71'(es_to_ms_bus[63:32]), 71'hF00F_F00F);
        check("xor es_dest", 71'(es_dest), 71'd11);
        ds_to_es_bus = mk(OP_SRA, 3'b000, 1'b0, 1'b1, 1'b0, 5'd12, 32'h8000_0000, 32'd4,
                          32'd0, PC0);
        step();
        check("sra result", 71'(es_to_ms_bus[63:32]), 71'hF800_0000);
        ds_to_es_bus = mk(OP_SLT, 3'b000, 1'b0, 1'b1, 1'b0, 5'd13, 32'hFFFF_FFFF, 32'd1,
                          32'd0, PC0);
        step();
        ds_to_es_valid = 1'b0;
        check("slt result", 71'(es_to_ms_bus[63:32]), 71'd1);
        step();
        check("pipe empty", 71'(es_to_ms_valid), 71'd0);

`ifdef EXE_DIV_EN
        run_div("divu 100/7", 32'd100, 32'd7, 3'b100, 32'd14, 0);
        run_div("modu 100%7", 32'd100, 32'd7, 3'b101, 32'd2, 0);
        run_div("div -7/2", 32'hFFFF_FFF9, 32'd2, 3'b110, 32'hFFFF_FFFD, 0);
        run_div("mod -7%2", 32'hFFFF_FFF9, 32'd2, 3'b111, 32'hFFFF_FFFF, 0);
        run_div("div min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 3'b110, 32'h8000_0000, 0);
        run_div("mod min%-1", 32'h8000_0000, 32'hFFFF_FFFF, 3'b111, 32'd0, 0);
        run_div("divu 9/0", 32'd9, 32'd0, 3'b100, 32'hFFFF_FFFF, 0);
        run_div("mod 9%0", 32'd9, 32'd0, 3'b111, 32'd9, 0);
        run_div("divu hold", 32'd1000, 32'd10, 3'b100, 32'd100, 5);

        // reset during BUSY iteration 10
        ds_to_es_bus   = mk(OP_ADD, 3'b100, 1'b0, 1'b1, 1'b0, 5'd4, 32'd50, 32'd5, 32'd0, PC0);
        ds_to_es_valid = 1'b1;
        step();
        ds_to_es_valid = 1'b0;
        for (int i = 0; i < 11; i++) step();
        reset = 1'b1;
        #1;
        check("abort valid", 71'(es_to_ms_valid), 71'd0);
        check("abort allowin", 71'(es_allowin), 71'd1);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            check("abort no emit", 71'(es_to_ms_valid), 71'd0);
        end
`else
        // divider absent: div_op is ignored and the ALU add result appears after one cycle
        ds_to_es_bus   = mk(OP_ADD, 3'b100, 1'b0, 1'b1, 1'b0, 5'd2, 32'd100, 32'd7, 32'd0, PC0);
        ds_to_es_valid = 1'b1;
        step();
        ds_to_es_valid = 1'b0;
        check("nodiv valid", 71'(es_to_ms_valid), 71'd1);
        check("nodiv result", 71'(es_to_ms_bus[63:32]), 71'd107);
        check("nodiv allowin", 71'(es_allowin), 71'd1);
        step();
        check("nodiv drained", 71'(es_to_ms_valid), 71'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
